// File: rtl/phase_cmd_pkg.sv
// Shared opcodes, response codes, offset width and decoder state encoding
// for the phase array command decoder.
package phase_cmd_pkg;

    localparam int OFFSET_W = 24;

    localparam logic [7:0] OP_PING   = 8'h00;
    localparam logic [7:0] OP_SET    = 8'h01;
    localparam logic [7:0] OP_COMMIT = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;

    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;
    localparam logic [7:0] RSP_PING = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CH,
        ST_GET_B2,
        ST_GET_B1,
        ST_GET_B0,
        ST_RESP
    } state_t;

endpackage

// File: rtl/phase_resp_tx.sv
// Response sequencer: loaded with a 1- or 3-byte count and a 24-bit payload,
// presents the bytes MSB first on a registered valid/ready output.
module phase_resp_tx
    import phase_cmd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [1:0]          count_i,
    input  logic [OFFSET_W-1:0] payload_i,
    output logic [7:0]          m_tdata_o,
    output logic                m_tvalid_o,
    input  logic                m_tready_i,
    output logic                done_o
);

    logic [7:0]  data_q, data_d;
    logic [15:0] rest_q, rest_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        rest_d  = rest_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
            cnt_d   = count_i;
            if (count_i == 2'd3) begin
                data_d = payload_i[23:16];
                rest_d = payload_i[15:0];
            end else begin
                data_d = payload_i[7:0];
                rest_d = 16'h0000;
            end
        end else if (valid_q && m_tready_i) begin
            // Next byte appears the cycle after each handshake.
            if (cnt_q > 2'd1) begin
                data_d = rest_q[15:8];
                rest_d = {rest_q[7:0], 8'h00};
                cnt_d  = cnt_q - 2'd1;
            end else begin
                valid_d = 1'b0;
                cnt_d   = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= 8'h00;
            rest_q  <= 16'h0000;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            rest_q  <= rest_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign m_tdata_o  = data_q;
    assign m_tvalid_o = valid_q;
    assign done_o     = valid_q && m_tready_i && (cnt_q == 2'd1);

endmodule

// File: rtl/phase_cmd_decoder.sv
// UART byte command decoder with shadow/active phase offset banks and reload pulse.
// Optional inter-byte timeout enabled by defining PHASE_CMD_TIMEOUT_EN.
module phase_cmd_decoder
    import phase_cmd_pkg::*;
#(
    parameter int OUTPUTS        = 16,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic [7:0]                  m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [OFFSET_W*OUTPUTS-1:0] offsets,
    output logic                        reload_n
);

    localparam logic [8:0] NUM_CH = 9'(OUTPUTS);

    state_t state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] ch_q, ch_d;
    logic [7:0] b2_q, b2_d;
    logic [7:0] b1_q, b1_d;
    logic       rdy_q;
    logic       reload_n_q;

    logic                accept;
    logic                load;
    logic [1:0]          load_cnt;
    logic [OFFSET_W-1:0] load_payload;
    logic [OFFSET_W-1:0] rd_data;
    logic                set_we;
    logic                commit;
    logic                rsp_done;

    // rdy_q keeps s_tready low while reset is held and for the release edge.
    assign s_tready = rdy_q && (state_q != ST_RESP);
    assign accept   = s_tvalid && s_tready;
    assign reload_n = reload_n_q;

`ifdef PHASE_CMD_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        in_get;
    logic        tmo_hit;

    always_comb begin
        in_get  = (state_q == ST_GET_CH) || (state_q == ST_GET_B2) ||
                  (state_q == ST_GET_B1) || (state_q == ST_GET_B0);
        tmo_hit = in_get && !accept && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
        tmo_d   = (in_get && !accept && !tmo_hit) ? tmo_q + 32'd1 : 32'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= 32'd0;
        else      tmo_q <= tmo_d;
    end
`else
    // Timeout disabled: parameter only kept for a uniform instantiation interface.
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < OUTPUTS; j++) begin
            if (s_tdata == 8'(j)) rd_data = offsets[OFFSET_W*j +: OFFSET_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        ch_d         = ch_q;
        b2_d         = b2_q;
        b1_d         = b1_q;
        load         = 1'b0;
        load_cnt     = 2'd1;
        load_payload = '0;
        set_we       = 1'b0;
        commit       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = s_tdata;
                    case (s_tdata)
                        OP_SET, OP_READ: state_d = ST_GET_CH;
                        OP_PING: begin
                            load         = 1'b1;
                            load_payload = {16'h0000, RSP_PING};
                            state_d      = ST_RESP;
                        end
                        OP_COMMIT: begin
                            commit       = 1'b1;
                            load         = 1'b1;
                            load_payload = {16'h0000, RSP_ACK};
                            state_d      = ST_RESP;
                        end
                        default: begin
                            load         = 1'b1;
                            load_payload = {16'h0000, RSP_NAK};
                            state_d      = ST_RESP;
                        end
                    endcase
                end
            end
            ST_GET_CH: begin
                if (accept) begin
                    ch_d = s_tdata;
                    if (op_q == OP_SET) begin
                        state_d = ST_GET_B2;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_RESP;
                        if ({1'b0, s_tdata} < NUM_CH) begin
                            load_cnt     = 2'd3;
                            load_payload = rd_data;
                        end else begin
                            load_payload = {16'h0000, RSP_NAK};
                        end
                    end
                end
            end
            ST_GET_B2: begin
                if (accept) begin
                    b2_d    = s_tdata;
                    state_d = ST_GET_B1;
                end
            end
            ST_GET_B1: begin
                if (accept) begin
                    b1_d    = s_tdata;
                    state_d = ST_GET_B0;
                end
            end
            ST_GET_B0: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = ST_RESP;
                    if ({1'b0, ch_q} < NUM_CH) begin
                        set_we       = 1'b1;
                        load_payload = {16'h0000, RSP_ACK};
                    end else begin
                        load_payload = {16'h0000, RSP_NAK};
                    end
                end
            end
            ST_RESP: begin
                if (rsp_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef PHASE_CMD_TIMEOUT_EN
        if (tmo_hit) begin
            load         = 1'b1;
            load_cnt     = 2'd1;
            load_payload = {16'h0000, RSP_NAK};
            state_d      = ST_RESP;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 8'h00;
            ch_q       <= 8'h00;
            b2_q       <= 8'h00;
            b1_q       <= 8'h00;
            rdy_q      <= 1'b0;
            reload_n_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ch_q       <= ch_d;
            b2_q       <= b2_d;
            b1_q       <= b1_d;
            rdy_q      <= 1'b1;
            reload_n_q <= !commit;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUTPUTS; gi++) begin : g_ch
            logic [OFFSET_W-1:0] shadow_q;
            logic [OFFSET_W-1:0] active_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shadow_q <= OFFSET_W'(gi * 10);
                    active_q <= OFFSET_W'(gi * 10);
                end else begin
                    if (set_we && (ch_q == 8'(gi))) shadow_q <= {b2_q, b1_q, s_tdata};
                    if (commit) active_q <= shadow_q;
                end
            end

            assign offsets[OFFSET_W*gi +: OFFSET_W] = active_q;
        end
    endgenerate

    phase_resp_tx u_resp_tx (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .count_i    (load_cnt),
        .payload_i  (load_payload),
        .m_tdata_o  (m_tdata),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready),
        .done_o     (rsp_done)
    );

endmodule
